baud_rate_gen: RTL and testbench
================================

Name: baud_rate_gen

Overview:
- Free-running modulo-N_COUNT counter that emits a single-cycle `tick` strobe every N_COUNT clock cycles.
- It is the oversampling time base for the UART RX/TX blocks.
- Defaults target a 50 MHz clock at 16x oversampling of 19200 baud: 50e6/(19200*16) ≈ 163, giving a tick rate of about 306.7 kHz.

Parameters:
- N_BITS, 8: width of the internal counter; must satisfy 2**N_BITS >= N_COUNT.
- N_COUNT, 163: tick period in clock cycles; legal range 2 .. 2**N_BITS.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- tick  output  1  registered strobe, high for exactly one clock cycle per period.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset:
  - On a rising edge with reset=1: count <= 0 and tick <= 0.
  - Reset has priority over counting.
- Counting, on each rising edge with reset=0:
  - if count == N_COUNT-1: count <= 0, tick <= 1;
  - else: count <= count+1, tick <= 0.
- Latency:
  - Number the rising edges with reset low starting at 1.
  - tick goes high after edge N_COUNT, 2*N_COUNT, 3*N_COUNT, …
  - Each high lasts exactly 1 cycle. The first tick follows N_COUNT cycles after reset release.
- Period: rising-edge to rising-edge spacing of tick is exactly N_COUNT cycles. Duty is 1/N_COUNT. No two consecutive high cycles.
- Wrap-around: the counter never exceeds N_COUNT-1. Counter arithmetic is unsigned, N_BITS wide, and the N_COUNT-1 compare is done at N_BITS width.
- Reset mid-period:
  - Clears the phase completely; the next tick is again N_COUNT cycles after release.
  - If reset coincides with the terminal count, reset wins and tick stays 0.
- tick must be glitch-free, driven directly from a flop; no combinational output path.
- Elaboration-time checks:
  - N_COUNT < 2 is an error.
  - N_COUNT > 2**N_BITS is an error.

Optional Feature:
- Macro: BAUD_RATE_GEN_BIT_TICK_EN.
- When defined:
  - Adds output port `bit_tick` (1 bit) and a 4-bit oversample counter.
  - The oversample counter increments on every tick and wraps at 15.
  - `bit_tick` is registered and high for one cycle coincident with every 16th tick, i.e. the same cycle as the tick that wraps the oversample counter 15→0.
  - Both the oversample counter and bit_tick reset to 0.
- When undefined: the port and the extra counter do not exist. Behaviour and port list are exactly as above.

Decomposition:
- Package baud_rate_pkg holds:
  - CLK_FREQ_HZ = 50_000_000
  - BAUD_RATE = 19200
  - OVERSAMPLE = 16
  - DEFAULT_N_COUNT = 163, computed as CLK_FREQ_HZ/(BAUD_RATE*OVERSAMPLE) rounded
  - DEFAULT_N_BITS = 8
- Sub-module mod_counter (parameters WIDTH, MODULUS; outputs count and wrap strobe) is natural. It is instantiated once for the main divider and once more for the optional oversample counter.

Test Plan:
- Reset held 2 cycles, then released, defaults → tick=0 throughout reset; first tick high for exactly 1 cycle after the 163rd post-reset edge.
- Free-run 400000 cycles → every tick-to-tick interval is exactly 163 cycles; no pulse wider than 1 cycle; tick count = floor(400000/163) ±1.
- Reset asserted for 1 cycle at count 80 → tick stays 0; next tick is 163 cycles after release, not 82.
- Reset asserted on the terminal-count edge → no tick that cycle; the period restarts from 0.
- Parameter override N_COUNT=2, N_BITS=1 → tick alternates 0/1 every cycle after reset. N_COUNT=256, N_BITS=8 → period 256 and the counter wraps cleanly from 255.
- With BAUD_RATE_GEN_BIT_TICK_EN, defaults → bit_tick high 1 cycle every 16*163=2608 cycles, aligned with the 16th tick; bit_tick is 0 during reset.

Source files
------------

// File: rtl/baud_rate_pkg.sv
// Shared UART timing constants for the baud-rate time base.
// DEFAULT_N_COUNT is the clock-to-oversample divide ratio, rounded to nearest.
package baud_rate_pkg;

    localparam int unsigned CLK_FREQ_HZ     = 50_000_000;
    localparam int unsigned BAUD_RATE       = 19200;
    localparam int unsigned OVERSAMPLE      = 16;
    localparam int unsigned OVERSAMPLE_BITS = 4;

    localparam int unsigned DEFAULT_N_COUNT =
        (CLK_FREQ_HZ + (BAUD_RATE * OVERSAMPLE) / 2) / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DEFAULT_N_BITS  = 8;

endpackage

// File: rtl/baud_rate_gen_mod_counter.sv
// Enabled modulo-MODULUS counter with a registered one-cycle wrap strobe.
// The strobe rises on the same edge that returns the count to zero.
module baud_rate_gen_mod_counter
    import baud_rate_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_N_BITS,
    parameter int unsigned MODULUS = DEFAULT_N_COUNT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap
);

    // Terminal value compared at the counter's own width, so MODULUS = 2**WIDTH works.
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (i_en) begin
                if (r_count == LAST) begin
                    r_count <= '0;
                    r_wrap  <= 1'b1;
                end else begin
                    r_count <= r_count + WIDTH'(1);
                end
            end
        end
    end

    assign o_count = r_count;
    assign o_wrap  = r_wrap;

endmodule

// File: rtl/baud_rate_gen.sv
// Oversampling time base for UART RX/TX: one-cycle tick every N_COUNT clocks.
// Define BAUD_RATE_GEN_BIT_TICK_EN to add bit_tick, coincident with every 16th tick.
module baud_rate_gen
    import baud_rate_pkg::*;
#(
    parameter int unsigned N_BITS  = DEFAULT_N_BITS,
    parameter int unsigned N_COUNT = DEFAULT_N_COUNT
) (
    input  logic clock,
    input  logic reset,
    output logic tick
`ifdef BAUD_RATE_GEN_BIT_TICK_EN
    ,
    output logic bit_tick
`endif
);

    if (N_COUNT < 2) begin : g_chk_min
        $error("baud_rate_gen: N_COUNT (%0d) must be at least 2", N_COUNT);
    end
    if (64'(N_COUNT) > (64'd1 << N_BITS)) begin : g_chk_max
        $error("baud_rate_gen: N_COUNT (%0d) exceeds 2**N_BITS (N_BITS=%0d)", N_COUNT, N_BITS);
    end

    logic [N_BITS-1:0] w_main_count;

    baud_rate_gen_mod_counter #(
        .WIDTH   (N_BITS),
        .MODULUS (N_COUNT)
    ) u_main_div (
        .clock   (clock),
        .reset   (reset),
        .i_en    (1'b1),
        .o_count (w_main_count),
        .o_wrap  (tick)
    );

`ifdef BAUD_RATE_GEN_BIT_TICK_EN
    localparam logic [N_BITS-1:0] MAIN_LAST = N_BITS'(N_COUNT - 1);

    logic                       w_main_last;
    logic [OVERSAMPLE_BITS-1:0] w_unused_ovs_count;

    // Advance on the edge that raises tick, so bit_tick lands in the same cycle as tick.
    assign w_main_last = (w_main_count == MAIN_LAST);

    baud_rate_gen_mod_counter #(
        .WIDTH   (OVERSAMPLE_BITS),
        .MODULUS (OVERSAMPLE)
    ) u_ovs_div (
        .clock   (clock),
        .reset   (reset),
        .i_en    (w_main_last),
        .o_count (w_unused_ovs_count),
        .o_wrap  (bit_tick)
    );
`else
    logic w_unused_main_count;
    assign w_unused_main_count = ^w_main_count;
`endif

endmodule

// File: tb/tb_baud_rate_gen.sv
// Directed bench for baud_rate_gen: default, N_COUNT=2 and N_COUNT=256 instances.
// Expected tick after post-reset edge n is (n % N_COUNT == 0); bit_tick uses 16*N_COUNT.
module tb_baud_rate_gen;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic tick_dflt;
    logic tick_n2;
    logic tick_n256;
`ifdef BAUD_RATE_GEN_BIT_TICK_EN
    logic bit_tick_dflt;
    logic bit_tick_n2;
    logic bit_tick_n256;
`endif

    int n_checks  = 0;
    int n_errors  = 0;
    int n_edge    = 0;
    int ticks_dflt = 0;
    int ticks_n2   = 0;
    int ticks_n256 = 0;
    int last_tick_edge = 0;

    always #5 clock = ~clock;

    baud_rate_gen u_dut_dflt (
        .clock    (clock),
        .reset    (reset),
`ifdef BAUD_RATE_GEN_BIT_TICK_EN
        .bit_tick (bit_tick_dflt),
`endif
        .tick     (tick_dflt)
    );

    baud_rate_gen #(
        .N_BITS  (1),
        .N_COUNT (2)
    ) u_dut_n2 (
        .clock    (clock),
        .reset    (reset),
`ifdef BAUD_RATE_GEN_BIT_TICK_EN
        .bit_tick (bit_tick_n2),
`endif
        .tick     (tick_n2)
    );

    baud_rate_gen #(
        .N_BITS  (8),
        .N_COUNT (256)
    ) u_dut_n256 (
        .clock    (clock),
        .reset    (reset),
`ifdef BAUD_RATE_GEN_BIT_TICK_EN
        .bit_tick (bit_tick_n256),
`endif
        .tick     (tick_n256)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, got, exp, n_edge,
                     $time);
        end
    endtask

    function automatic logic [31:0] exp_strobe(input bit rst, input int n, input int period);
        return (!rst && n > 0 && (n % period) == 0) ? 32'd1 : 32'd0;
    endfunction

    // One rising edge, then sample 1 time unit later against the edge-number model.
    task automatic step_and_check();
        bit rst_seen;
        rst_seen = reset;
        @(posedge clock);
        #1;
        if (rst_seen) begin
            n_edge         = 0;
            last_tick_edge = 0;
        end else begin
            n_edge++;
        end
        check_eq("tick_dflt", {31'b0, tick_dflt}, exp_strobe(rst_seen, n_edge, 163));
        check_eq("tick_n2", {31'b0, tick_n2}, exp_strobe(rst_seen, n_edge, 2));
        check_eq("tick_n256", {31'b0, tick_n256}, exp_strobe(rst_seen, n_edge, 256));
`ifdef BAUD_RATE_GEN_BIT_TICK_EN
        check_eq("bit_tick_dflt", {31'b0, bit_tick_dflt}, exp_strobe(rst_seen, n_edge, 2608));
        check_eq("bit_tick_n2", {31'b0, bit_tick_n2}, exp_strobe(rst_seen, n_edge, 32));
        check_eq("bit_tick_n256", {31'b0, bit_tick_n256}, exp_strobe(rst_seen, n_edge, 4096));
`endif
        if (tick_dflt) begin
            ticks_dflt++;
            if (last_tick_edge > 0) begin
                check_eq("period_dflt", 32'(n_edge - last_tick_edge), 32'd163);
            end
            last_tick_edge = n_edge;
        end
        if (tick_n2) ticks_n2++;
        if (tick_n256) ticks_n256++;
    endtask

    initial begin
        // Reset for two edges, then free-run.
        reset = 1'b1;
        repeat (2) step_and_check();
        reset = 1'b0;
        ticks_dflt = 0;
        ticks_n2   = 0;
        ticks_n256 = 0;
        repeat (6000) step_and_check();
        check_eq("count_dflt", 32'(ticks_dflt), 32'd36);
        check_eq("count_n2", 32'(ticks_n2), 32'd3000);
        check_eq("count_n256", 32'(ticks_n256), 32'd23);

        // Reset mid-period with the default counter at 80.
        reset = 1'b1;
        step_and_check();
        reset = 1'b0;
        repeat (80) step_and_check();
        reset = 1'b1;
        step_and_check();
        reset = 1'b0;
        repeat (170) step_and_check();

        // Reset on the default counter's terminal-count edge.
        reset = 1'b1;
        step_and_check();
        reset = 1'b0;
        repeat (162) step_and_check();
        reset = 1'b1;
        step_and_check();
        reset = 1'b0;
        repeat (170) step_and_check();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
